// File: rtl/mac_dot_seq_pkg.sv
// Shared constants, counter types and FSM encoding for the dot-product sequencer.
package mac_dot_seq_pkg;
  localparam int MAC_LAT = 4;
  localparam int LANES   = MAC_LAT + 1;
  localparam int LEN_W   = 16;
  localparam int A_W     = 25;
  localparam int B_W     = 18;
  localparam int P_W     = 48;
  localparam int SLOT_W  = $clog2(LANES + 1);

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [LEN_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/mac_dot_reduce.sv
// Collects the LANES partial sums leaving the MAC after the last RUN slot and adds them into RES.
module mac_dot_reduce
  import mac_dot_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [P_W-1:0] mac_p,
  output logic [P_W-1:0] res,
  output logic           done
);
  slot_t          cnt;
  logic [P_W-1:0] sum;

  // done is high during the cycle before the final sample edge, so the
  // caller can switch state on the same edge that loads res.
  assign done = (cnt == slot_t'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sum <= '0;
      res <= '0;
    end else if (start) begin
      cnt <= slot_t'(LANES);
      sum <= '0;
    end else if (cnt != '0) begin
      sum <= sum + mac_p;
      cnt <= cnt - slot_t'(1);
      if (done) res <= sum + mac_p;
    end
  end
endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: interleaves LANES partial sums through a 4-stage MAC, then reduces them.
// Build option DOTSEQ_PREADD_EN adds the IN_D pre-add operand (result = sum (a+d)*b).
module mac_dot_seq
  import mac_dot_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [A_W-1:0]   IN_A,
  input  logic [B_W-1:0]   IN_B,
`ifdef DOTSEQ_PREADD_EN
  input  logic [A_W-1:0]   IN_D,
`endif
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [P_W-1:0]   RES,
  output logic [A_W-1:0]   MAC_A,
  output logic [B_W-1:0]   MAC_B,
  output logic [P_W-1:0]   MAC_C,
  output logic [A_W-1:0]   MAC_D,
  output logic             MAC_SCLR,
  input  logic [P_W-1:0]   MAC_P,
  output logic [1:0]       DBG_STATE
);
  // Handshakes: a transfer happens on a rising CLK edge where valid and ready
  // are both high; RES_VALID/RES stay put until that edge.
  state_t state;
  slot_t  slot;
  cnt_t   len_q;
  cnt_t   accepted;
  logic   accept;
  logic   last_slot;
  logic   red_done;

  assign BUSY      = (state != ST_IDLE);
  assign IN_READY  = (state == ST_RUN) && (accepted < len_q);
  assign accept    = IN_VALID && IN_READY;
  assign last_slot = (state == ST_RUN) &&
                     ((accepted + cnt_t'(accept)) == len_q) &&
                     (slot >= slot_t'(LANES - 1));
  assign DBG_STATE = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      slot      <= '0;
      len_q     <= '0;
      accepted  <= '0;
      MAC_A     <= '0;
      MAC_B     <= '0;
      MAC_C     <= '0;
      RES_VALID <= 1'b0;
      MAC_SCLR  <= 1'b1;
    end else begin
      MAC_SCLR <= 1'b0;
      MAC_A    <= '0;
      MAC_B    <= '0;
      MAC_C    <= '0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            len_q    <= LEN;
            slot     <= '0;
            accepted <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            MAC_A    <= IN_A;
            MAC_B    <= IN_B;
            accepted <= accepted + cnt_t'(1);
          end
          // First LANES slots seed each lane from zero; afterwards P returns
          // to C exactly when the same lane comes round again.
          MAC_C <= (slot < slot_t'(LANES)) ? '0 : MAC_P;
          if (slot < slot_t'(LANES)) slot <= slot + slot_t'(1);
          if (last_slot) state <= ST_REDUCE;
        end
        ST_REDUCE: begin
          if (red_done) begin
            RES_VALID <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DOTSEQ_PREADD_EN
  logic [A_W-1:0] mac_d_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mac_d_q <= '0;
    else     mac_d_q <= accept ? IN_D : '0;
  end
  assign MAC_D = mac_d_q;
`else
  assign MAC_D = '0;
`endif

  mac_dot_reduce u_reduce (
    .clk   (CLK),
    .rst   (RST),
    .start (last_slot),
    .mac_p (MAC_P),
    .res   (RES),
    .done  (red_done)
  );
endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural 4-stage pre-add MAC closing the P->C loop.
module tb_mac_dot_seq;
  import mac_dot_seq_pkg::*;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [15:0] LEN;
  logic        BUSY;
  logic        IN_VALID;
  logic        IN_READY;
  logic [24:0] IN_A;
  logic [17:0] IN_B;
`ifdef DOTSEQ_PREADD_EN
  logic [24:0] IN_D;
`endif
  logic        RES_VALID;
  logic        RES_READY;
  logic [47:0] RES;
  logic [24:0] MAC_A;
  logic [17:0] MAC_B;
  logic [47:0] MAC_C;
  logic [24:0] MAC_D;
  logic        MAC_SCLR;
  logic [47:0] mac_p;
  logic [1:0]  DBG_STATE;

  int n_vec;
  int n_err;
  logic [47:0] exp_q[$];
  int a_v[64];
  int b_v[64];
  int d_v[64];

  mac_dot_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .LEN       (LEN),
    .BUSY      (BUSY),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
`ifdef DOTSEQ_PREADD_EN
    .IN_D      (IN_D),
`endif
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES       (RES),
    .MAC_A     (MAC_A),
    .MAC_B     (MAC_B),
    .MAC_C     (MAC_C),
    .MAC_D     (MAC_D),
    .MAC_SCLR  (MAC_SCLR),
    .MAC_P     (mac_p),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- MAC model: in-reg, multiply, pipe, P ----------------
  logic signed [24:0] m1_a, m1_d;
  logic signed [17:0] m1_b;
  logic [47:0]        m1_c, m2_c, m3_c, m2_m, m3_m;
  logic signed [25:0] pre;
  logic signed [43:0] prod;

  always_comb begin
    pre  = {m1_a[24], m1_a} + {m1_d[24], m1_d};
    prod = pre * m1_b;
  end

  always @(posedge CLK) begin
    if (MAC_SCLR) begin
      m1_a <= '0; m1_b <= '0; m1_c <= '0; m1_d <= '0;
      m2_m <= '0; m2_c <= '0; m3_m <= '0; m3_c <= '0; mac_p <= '0;
    end else begin
      m1_a  <= MAC_A; m1_b <= MAC_B; m1_c <= MAC_C; m1_d <= MAC_D;
      m2_m  <= {{4{prod[43]}}, prod};
      m2_c  <= m1_c;
      m3_m  <= m2_m;
      m3_c  <= m2_c;
      mac_p <= m3_m + m3_c;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_job(input string tag, input int len, input bit toggle,
                         input logic [47:0] exp, input int hold);
    int idx, guard, lat, exp_lat;
    bit acc;
    logic [47:0] want;
    exp_q.push_back(exp);
    @(negedge CLK);
    START = 1'b1;
    LEN   = 16'(len);
    @(negedge CLK);
    START = 1'b0;
    check({tag, "_busy"}, BUSY, 1);
    idx = 0; guard = 0;
    while (idx < len && guard < 2000) begin
      IN_VALID = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      IN_A = 25'(a_v[idx]);
      IN_B = 18'(b_v[idx]);
`ifdef DOTSEQ_PREADD_EN
      IN_D = 25'(d_v[idx]);
`endif
      acc = IN_VALID && IN_READY;
      @(posedge CLK);
      if (acc) idx++;
      guard++;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    check({tag, "_fed"}, 64'(idx), 64'(len));
    lat = 0;
    while (!RES_VALID && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, "_res_valid"}, RES_VALID, 1);
    if (!toggle) begin
      exp_lat = (len >= LANES) ? 5 : 10 - len;
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    end
    want = exp_q.pop_front();
    check({tag, "_res"}, RES, want);
    for (int i = 0; i < hold; i++) begin
      START = 1'b1;
      LEN   = 16'd7;
      @(negedge CLK);
      check({tag, "_hold_res"}, RES, want);
      check({tag, "_hold_state"}, DBG_STATE, ST_DONE);
      check({tag, "_hold_in_ready"}, IN_READY, 0);
    end
    START     = 1'b0;
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    check({tag, "_released"}, RES_VALID, 0);
    check({tag, "_idle"}, BUSY, 0);
  endtask

  // ---------------- sequence ----------------
  longint      gsum;
  logic [63:0] gs;

  initial begin
    n_vec = 0; n_err = 0;
    RST = 1'b1; START = 1'b0; LEN = '0; IN_VALID = 1'b0;
    IN_A = '0; IN_B = '0; RES_READY = 1'b0;
`ifdef DOTSEQ_PREADD_EN
    IN_D = '0;
`endif
    for (int i = 0; i < 64; i++) d_v[i] = 0;
    repeat (3) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_in_ready", IN_READY, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res", RES, 0);
    check("rst_mac_a", MAC_A, 0);
    check("rst_mac_c", MAC_C, 0);
    check("rst_sclr", MAC_SCLR, 1);
    RST = 1'b0;
    #1 check("sclr_held", MAC_SCLR, 1);
    @(negedge CLK);
    check("sclr_drop", MAC_SCLR, 0);

    for (int i = 0; i < 8; i++) begin a_v[i] = i + 1; b_v[i] = 1; end
    run_job("len8", 8, 1'b0, 48'd36, 0);

    a_v[0] = -2; a_v[1] = 5; a_v[2] = 7;
    b_v[0] = 3;  b_v[1] = -4; b_v[2] = 2;
    run_job("len3", 3, 1'b0, -48'sd12, 0);

    gsum = 0;
    for (int i = 0; i < 20; i++) begin
      a_v[i] = int'($urandom_range(0, 33554431)) - 16777216;
      b_v[i] = int'($urandom_range(0, 262143)) - 131072;
      gsum += longint'(a_v[i]) * longint'(b_v[i]);
    end
    gs = gsum;
    run_job("rand20", 20, 1'b1, gs[47:0], 0);

    run_job("len0", 0, 1'b0, 48'd0, 10);
    for (int i = 0; i < 6; i++) begin a_v[i] = 3; b_v[i] = 3; end
    run_job("b2b6", 6, 1'b0, 48'd54, 10);

    // abort mid-job
    @(negedge CLK);
    START = 1'b1; LEN = 16'd16;
    @(negedge CLK);
    START = 1'b0; IN_VALID = 1'b1; IN_A = 25'd1; IN_B = 18'd1;
    repeat (6) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_in_ready", IN_READY, 0);
    check("abort_res_valid", RES_VALID, 0);
    check("abort_res", RES, 0);
    check("abort_mac_a", MAC_A, 0);
    check("abort_mac_b", MAC_B, 0);
    check("abort_mac_c", MAC_C, 0);
    check("abort_sclr", MAC_SCLR, 1);
    check("abort_state", DBG_STATE, ST_IDLE);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("abort_sclr_drop", MAC_SCLR, 0);

    for (int i = 0; i < 4; i++) begin a_v[i] = 2; b_v[i] = 2; end
    run_job("len4", 4, 1'b0, 48'd16, 0);

    for (int i = 0; i < 40; i++) begin a_v[i] = -16777216; b_v[i] = -131072; end
    run_job("wrap40", 40, 1'b0, 48'h5000_0000_0000, 0);

`ifdef DOTSEQ_PREADD_EN
    a_v[0] = 3; a_v[1] = 1;
    d_v[0] = 1; d_v[1] = 1;
    b_v[0] = 2; b_v[1] = 5;
    run_job("preadd", 2, 1'b0, 48'd18, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
